// File: rtl/eightbit_pkg.sv
// Shared constants and FSM state encoding for the bit-serial 8-bit negator.
package eightbit_pkg;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/eightbit_negate_seq_cell.sv
// One-bit negation slice: s = ~a ^ c, c_next = ~a & c, built around the library NOT gate.
module not_gate (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module serial_negate_cell (
  input  logic a,
  input  logic c,
  output logic s,
  output logic c_next
);
  logic a_n;

  not_gate u_not (
    .a (a),
    .y (a_n)
  );

  assign s      = a_n ^ c;
  assign c_next = a_n & c;
endmodule

// File: rtl/eightbit_negate_seq.sv
// Bit-serial two's-complement negator, LSB first, one bit per clock.
// Optional overflow flag (operand == 0x80) is built only when EIGHTBIT_NEG_OVF_EN is defined.
module eightbit_negate_seq
  import eightbit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_zero,
  output logic              out_ovf
);

  state_t            state, next_state;
  logic [WORD_W-1:0] operand, operand_rot, result;
  logic [CNT_W-1:0]  count;
  logic              carry, zero_flag, s, c_next, last_bit, accept;

  // The operand rotates rather than shifts, so after the eighth bit it holds the original word again.
  assign operand_rot = {operand[0], operand[WORD_W-1:1]};
  assign last_bit    = (count == CNT_W'(WORD_W - 1));
  assign accept      = (state == IDLE) && in_valid;

  serial_negate_cell u_cell (
    .a      (operand[0]),
    .c      (carry),
    .s      (s),
    .c_next (c_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_bit)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand   <= '0;
      result    <= '0;
      count     <= '0;
      carry     <= 1'b1;
      zero_flag <= 1'b0;
    end else if (accept) begin
      operand   <= in_data;
      result    <= '0;
      count     <= '0;
      carry     <= 1'b1;
      zero_flag <= 1'b0;
    end else if (state == RUN) begin
      operand <= operand_rot;
      result  <= {s, result[WORD_W-1:1]};
      carry   <= c_next;
      count   <= count + 1'b1;
      if (last_bit) zero_flag <= c_next;
    end
  end

`ifdef EIGHTBIT_NEG_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           out_ovf <= 1'b0;
    else if (accept)                   out_ovf <= 1'b0;
    else if (state == RUN && last_bit) out_ovf <= (operand_rot == 8'h80);
  end
`else
  assign out_ovf = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = result;
  assign out_zero  = zero_flag;

endmodule

// File: tb/tb_eightbit_negate_seq.sv
// Directed self-checking bench for eightbit_negate_seq with hand-computed negation results.
module tb_eightbit_negate_seq;

`ifdef EIGHTBIT_NEG_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_zero;
  logic       out_ovf;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  eightbit_negate_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand for exactly one accepting edge, then confirm the block went busy.
  task automatic apply_stimulus(input logic [7:0] op);
    in_data  = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("busy_after_accept", {7'd0, in_ready}, 8'h00);
  endtask

  task automatic wait_result(input string tag, input logic [7:0] exp, input logic zero, input logic ovf);
    repeat (7) tick();
    check_output({tag, "_not_early"}, {7'd0, out_valid}, 8'h00);
    tick();
    check_output({tag, "_valid"}, {7'd0, out_valid}, 8'h01);
    check_output({tag, "_data"}, out_data, exp);
    check_output({tag, "_zero"}, {7'd0, out_zero}, {7'd0, zero});
    check_output({tag, "_ovf"}, {7'd0, out_ovf}, {7'd0, ovf});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, "_idle_ready"}, {7'd0, in_ready}, 8'h01);
    check_output({tag, "_idle_valid"}, {7'd0, out_valid}, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, {7'd0, in_ready}, 8'h01);
    check_output({tag, "_out_valid"}, {7'd0, out_valid}, 8'h00);
    check_output({tag, "_out_data"}, out_data, 8'h00);
    check_output({tag, "_out_zero"}, {7'd0, out_zero}, 8'h00);
    check_output({tag, "_out_ovf"}, {7'd0, out_ovf}, 8'h00);
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();

    apply_stimulus(8'h05);
    wait_result("w05", 8'hFB, 1'b0, 1'b0);
    handshake("w05");

    apply_stimulus(8'h00);
    wait_result("w00", 8'h00, 1'b1, 1'b0);
    handshake("w00");

    apply_stimulus(8'hFF);
    wait_result("wFF", 8'h01, 1'b0, 1'b0);
    handshake("wFF");

    apply_stimulus(8'h80);
    wait_result("w80", 8'h80, 1'b0, OVF_ON);
    handshake("w80");

    // Back-pressure in DONE while a fresh operand is offered and must be ignored.
    apply_stimulus(8'h3C);
    wait_result("w3C", 8'hC4, 1'b0, 1'b0);
    in_data  = 8'h99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("hold_data", out_data, 8'hC4);
      check_output("hold_valid", {7'd0, out_valid}, 8'h01);
      check_output("hold_in_ready", {7'd0, in_ready}, 8'h00);
    end
    in_valid = 1'b0;
    handshake("w3C");

    // Asynchronous reset in the middle of RUN, after four bits of operand 0x12.
    apply_stimulus(8'h12);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    tick();
    rst = 1'b0;
    tick();
    apply_stimulus(8'h01);
    wait_result("after_reset", 8'hFF, 1'b0, 1'b0);
    handshake("after_reset");

    // Back-to-back words with out_ready held high: one accept every 10 cycles.
    out_ready = 1'b1;
    begin
      logic [7:0] ops [3];
      logic [7:0] exps [3];
      ops  = '{8'h01, 8'h7F, 8'hAA};
      exps = '{8'hFF, 8'h81, 8'h56};
      for (int w = 0; w < 3; w++) begin
        apply_stimulus(ops[w]);
        wait_result("b2b", exps[w], 1'b0, 1'b0);
        tick();
        check_output("b2b_ready_at_9", {7'd0, in_ready}, 8'h01);
      end
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
